// File: rtl/pipe_reg_skid.sv
// Pipeline register with a small circular skid buffer between two stages.
// in_ready depends only on occupancy, so there is no ready path through it.
module pipe_reg_skid #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = 16,
    parameter int DEPTH      = 2,
    parameter logic [CTRL_WIDTH-1:0] CTRL_SAFE = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         stall,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CTRL_WIDTH-1:0]        in_ctrl,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CTRL_WIDTH-1:0]        out_ctrl,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [CTRL_WIDTH-1:0] ctrl_mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic push;
    logic pop;

    always_comb begin
        in_ready  = (count_q < FULL);
        out_valid = (count_q != '0);
        push      = in_valid && in_ready && !flush;
        pop       = out_valid && out_ready && !stall && !flush;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is left unreset; outputs are masked whenever the stage is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            ctrl_mem_q[wr_ptr_q] <= in_ctrl;
            data_mem_q[wr_ptr_q] <= in_data;
        end
    end

    always_comb begin
        out_ctrl = CTRL_SAFE;
        out_data = '0;
        if (out_valid) begin
            out_ctrl = ctrl_mem_q[rd_ptr_q];
            out_data = data_mem_q[rd_ptr_q];
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Randomised and directed checks of pipe_reg_skid (DEPTH 2 and 3) against
// a queue-based model of the stage.
module tb_pipe_reg_skid;

    localparam int DW = 16;
    localparam int CWD = 8;
    localparam logic [CWD-1:0] SAFE = 8'h5A;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic flush, stall, in_valid, out_ready;
    logic [CWD-1:0] in_ctrl;
    logic [DW-1:0] in_data;

    logic ir2, ov2, ir3, ov3;
    logic [CWD-1:0] oc2, oc3;
    logic [DW-1:0] od2, od3;
    logic [1:0] c2, c3;

    int total = 0;
    int bad = 0;
    int max3 = 0;
    bit col = 1'b0;

    logic [CWD+DW-1:0] m2[$];
    logic [CWD+DW-1:0] m3[$];
    logic [DW-1:0] got3[$];

    always #5 clk = ~clk;

    pipe_reg_skid #(.DATA_WIDTH(DW), .CTRL_WIDTH(CWD), .DEPTH(2),
                    .CTRL_SAFE(SAFE)) u2 (
        .clk(clk), .reset(reset), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(ir2), .in_ctrl(in_ctrl),
        .in_data(in_data), .out_valid(ov2), .out_ready(out_ready),
        .out_ctrl(oc2), .out_data(od2), .count(c2));

    pipe_reg_skid #(.DATA_WIDTH(DW), .CTRL_WIDTH(CWD), .DEPTH(3),
                    .CTRL_SAFE(SAFE)) u3 (
        .clk(clk), .reset(reset), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(ir3), .in_ctrl(in_ctrl),
        .in_data(in_data), .out_valid(ov3), .out_ready(out_ready),
        .out_ctrl(oc3), .out_data(od3), .count(c3));

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: each stage is a FIFO of at most DEPTH entries.
    bit p2, o2, p3, o3;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m2.delete();
            m3.delete();
        end else if (flush) begin
            m2.delete();
            m3.delete();
        end else begin
            p2 = in_valid && (m2.size() < 2);
            o2 = (m2.size() != 0) && out_ready && !stall;
            p3 = in_valid && (m3.size() < 3);
            o3 = (m3.size() != 0) && out_ready && !stall;
            if (o2) void'(m2.pop_front());
            if (o3) void'(m3.pop_front());
            if (p2) m2.push_back({in_ctrl, in_data});
            if (p3) m3.push_back({in_ctrl, in_data});
        end
    end

    always @(negedge clk) begin
        logic [CWD+DW-1:0] h2, h3;
        h2 = (m2.size() != 0) ? m2[0] : {SAFE, 16'h0};
        h3 = (m3.size() != 0) ? m3[0] : {SAFE, 16'h0};
        if (int'(c3) > max3) max3 = int'(c3);
        chk("u2_count", 64'(c2), 64'(m2.size()));
        chk("u2_in_ready", 64'(ir2), 64'(m2.size() < 2));
        chk("u2_out_valid", 64'(ov2), 64'(m2.size() != 0));
        chk("u2_head", 64'({oc2, od2}), 64'(h2));
        chk("u3_count", 64'(c3), 64'(m3.size()));
        chk("u3_in_ready", 64'(ir3), 64'(m3.size() < 3));
        chk("u3_out_valid", 64'(ov3), 64'(m3.size() != 0));
        chk("u3_head", 64'({oc3, od3}), 64'(h3));
    end

    task automatic drive(input logic v, input logic [CWD-1:0] c,
                         input logic [DW-1:0] d, input logic ordy,
                         input logic st, input logic fl);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        stall     = st;
        flush     = fl;
    endtask

    task automatic tick();
        if (col && ov3 && out_ready && !stall && !flush)
            got3.push_back(od3);
        @(posedge clk);
        #2;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #1;
        chk("rst_valid", 64'(ov2), 0);
        chk("rst_ready", 64'(ir2), 1);
        chk("rst_ctrl", 64'(oc2), 64'(SAFE));
        chk("rst_data", 64'(od2), 0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // basic pass
        drive(1, 8'h21, 16'h11, 1, 0, 0);
        tick();
        chk("pass_valid", 64'(ov2), 1);
        chk("pass_data", 64'(od2), 64'h11);
        chk("pass_ctrl", 64'(oc2), 64'h21);
        drive(0, 0, 0, 1, 0, 0);
        tick();
        chk("pass_count", 64'(c2), 0);

        // fill and backpressure
        drive(1, 8'h01, 16'hA, 0, 0, 0);
        tick();
        drive(1, 8'h02, 16'hB, 0, 0, 0);
        tick();
        chk("fill_count", 64'(c2), 2);
        chk("fill_ready", 64'(ir2), 0);
        drive(1, 8'h03, 16'hC, 0, 0, 0);
        tick();
        chk("full_count", 64'(c2), 2);
        chk("full_head", 64'(od2), 64'hA);
        drive(0, 0, 0, 1, 0, 0);
        tick();
        chk("drain_b", 64'(od2), 64'hB);
        drive(1, 8'h03, 16'hC, 1, 0, 0);
        tick();
        chk("drain_c", 64'(od2), 64'hC);
        drive(0, 0, 0, 1, 0, 0);
        repeat (4) tick();
        chk("drain_empty", 64'(c2), 0);

        // stall
        drive(1, 8'h07, 16'h5, 0, 0, 0);
        tick();
        drive(0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_data", 64'(od2), 64'h5);
            chk("stall_count", 64'(c2), 1);
        end
        drive(0, 0, 0, 1, 0, 0);
        tick();
        chk("unstall_pop", 64'(c2), 0);

        // flush precedence
        drive(1, 8'h11, 16'h31, 0, 0, 0);
        tick();
        drive(1, 8'h12, 16'h32, 0, 0, 0);
        tick();
        chk("preflush_count", 64'(c2), 2);
        drive(1, 8'h13, 16'h33, 1, 1, 1);
        tick();
        chk("flush_count", 64'(c2), 0);
        chk("flush_valid", 64'(ov2), 0);
        chk("flush_ctrl", 64'(oc2), 64'(SAFE));
        chk("flush_data", 64'(od2), 0);
        chk("flush_count3", 64'(c3), 0);

        // wrap-around on the DEPTH=3 instance
        col = 1'b1;
        begin
            int idx;
            int budget;
            logic acc;
            idx = 1;
            budget = 0;
            while (idx <= 9 && budget < 300) begin
                drive(1, 8'(idx), 16'(idx), 1'($urandom_range(0, 1)), 0, 0);
                acc = ir3;
                tick();
                if (acc) idx++;
                budget++;
            end
            chk("wrap_budget", 64'(budget < 300), 1);
        end
        drive(0, 0, 0, 1, 0, 0);
        repeat (6) tick();
        col = 1'b0;
        chk("wrap_len", 64'(got3.size()), 9);
        for (int i = 0; i < 9; i++) begin
            if (i < got3.size())
                chk("wrap_order", 64'(got3[i]), 64'(i + 1));
        end
        chk("wrap_bound", 64'(max3 <= 3), 1);

        // asynchronous reset mid-operation
        drive(1, 8'h41, 16'h61, 0, 0, 0);
        tick();
        drive(1, 8'h42, 16'h62, 0, 0, 0);
        tick();
        chk("prerst_count", 64'(c2), 2);
        drive(0, 0, 0, 0, 0, 0);
        #1 reset = 1'b1;
        #1;
        chk("arst_count", 64'(c2), 0);
        chk("arst_valid", 64'(ov2), 0);
        chk("arst_ready", 64'(ir2), 1);
        chk("arst_ctrl", 64'(oc2), 64'(SAFE));
        chk("arst_data", 64'(od2), 0);
        tick();
        reset = 1'b0;
        drive(1, 8'h44, 16'h77, 0, 0, 0);
        tick();
        chk("post_rst_head", 64'(od2), 64'h77);
        chk("post_rst_count", 64'(c2), 1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 31) == 0));
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
